// File: rtl/bcd_stopwatch_core_if.sv
// rtl/bcd_stopwatch_core_if.sv - control/status bundle between button logic, stopwatch core and display driver
interface bcd_stopwatch_core_if #(
    parameter int DIGITS     = 4,
    parameter int EXT_DIGITS = 2
);
    logic [1:0]              mode;
    logic [4*EXT_DIGITS-1:0] ext_val;
    logic                    tick;
    logic                    start;
    logic                    stop;
    logic                    clear;
    logic                    lap;
    logic                    sel_lap;
    logic [4*DIGITS-1:0]     display;
    logic                    running;
    logic                    done;
    logic                    wrap;

    modport master (
        output mode, ext_val, tick, start, stop, clear, lap, sel_lap,
        input  display, running, done, wrap
    );

    modport slave (
        input  mode, ext_val, tick, start, stop, clear, lap, sel_lap,
        output display, running, done, wrap
    );
endinterface

// File: rtl/bcd_stopwatch_core.sv
// rtl/bcd_stopwatch_core.sv - BCD up/down stopwatch/timer with lap capture and start/stop/clear FSM
module bcd_stopwatch_core #(
    parameter int DIGITS     = 4,
    parameter int EXT_DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_stopwatch_core_if.slave   bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   lap_q;
    logic           wrap_q, wrap_d;
    logic [W-1:0]   start_val;
    logic [W-1:0]   all_nines;
    logic           count_up;

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign count_up = ~bus.mode[1];

    // Presets land in the top digits; out-of-range switch digits clamp to 9.
    always_comb begin
        all_nines = '0;
        start_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            all_nines[4*i +: 4] = 4'd9;
        end
        case (bus.mode)
            2'b00: start_val = '0;
            2'b10: start_val = all_nines;
            default: begin
                for (int i = 0; i < EXT_DIGITS; i++) begin
                    start_val[4*(DIGITS-EXT_DIGITS+i) +: 4] =
                        (bus.ext_val[4*i +: 4] > 4'd9) ? 4'd9 : bus.ext_val[4*i +: 4];
                end
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            count_d = start_val;
            state_d = IDLE;
        end else if (bus.stop) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else if (bus.start) begin
            if (state_q == IDLE || state_q == PAUSE) begin
                state_d = (!count_up && count_q == '0) ? DONE : RUN;
            end
        end else if (bus.tick && state_q == RUN) begin
            if (count_up) begin
                if (count_q == all_nines) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = bcd_inc(count_q);
                end
            end else if (count_q == '0 || count_q == W'(1)) begin
                // Floor at zero; a mode flip to down while at zero also finishes.
                count_d = '0;
                state_d = DONE;
            end else begin
                count_d = bcd_dec(count_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= start_val;
            lap_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            if (bus.lap && (state_q == RUN || state_q == PAUSE)) begin
                lap_q <= count_q;
            end
        end
    end

    assign bus.display = bus.sel_lap ? lap_q : count_q;
    assign bus.running = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// tb/tb_bcd_stopwatch_core.sv - directed self-checking bench for bcd_stopwatch_core
module tb_bcd_stopwatch_core;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    bcd_stopwatch_core_if #(.DIGITS(4), .EXT_DIGITS(2)) bus ();

    bcd_stopwatch_core #(.DIGITS(4), .EXT_DIGITS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        bus.tick = 1'b1;
        cyc(n);
        bus.tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        bus.mode = 2'b00; bus.ext_val = 8'h00; bus.tick = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
        bus.lap = 1'b0; bus.sel_lap = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        chk("reset_display", bus.display, 16'h0000);
        chk("reset_running", 16'(bus.running), 16'h0);
        chk("reset_done",    16'(bus.done),    16'h0);
        chk("reset_wrap",    16'(bus.wrap),    16'h0);

        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        chk("start_running", 16'(bus.running), 16'h1);
        ticks(12);
        chk("up_12", bus.display, 16'h0012);

        bus.mode = 2'b01; bus.ext_val = 8'h99;
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
        chk("preset_load", bus.display, 16'h9900);
        chk("clear_idle", 16'(bus.running), 16'h0);
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        ticks(99);
        chk("up_9999", bus.display, 16'h9999);
        chk("no_wrap_yet", 16'(bus.wrap), 16'h0);
        ticks(1);
        chk("rollover", bus.display, 16'h0000);
        chk("wrap_pulse", 16'(bus.wrap), 16'h1);
        chk("run_after_wrap", 16'(bus.running), 16'h1);
        cyc(1);
        chk("wrap_one_cycle", 16'(bus.wrap), 16'h0);

        bus.mode = 2'b10;
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
        chk("down_all9", bus.display, 16'h9999);
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        ticks(1);
        chk("down_ripple", bus.display, 16'h9998);

        bus.mode = 2'b11; bus.ext_val = 8'hA5;
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
        chk("clamp", bus.display, 16'h9500);

        bus.mode = 2'b00;
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        ticks(1);
        chk("timer_one", bus.display, 16'h0001);
        bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
        chk("paused", 16'(bus.running), 16'h0);
        bus.mode = 2'b11;
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        chk("resume_no_reload", bus.display, 16'h0001);
        chk("resume_running", 16'(bus.running), 16'h1);
        ticks(1);
        chk("timer_zero", bus.display, 16'h0000);
        chk("timer_done", 16'(bus.done), 16'h1);
        chk("timer_not_run", 16'(bus.running), 16'h0);
        ticks(3);
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        chk("done_hold_val", bus.display, 16'h0000);
        chk("done_hold", 16'(bus.done), 16'h1);

        bus.ext_val = 8'h00;
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
        chk("clear_from_done", 16'(bus.done), 16'h0);
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        chk("start_at_zero_done", 16'(bus.done), 16'h1);

        bus.mode = 2'b00;
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        ticks(37);
        bus.lap = 1'b1; cyc(1); bus.lap = 1'b0;
        ticks(5);
        bus.sel_lap = 1'b1; #1;
        chk("lap_display", bus.display, 16'h0037);
        bus.sel_lap = 1'b0; #1;
        chk("live_display", bus.display, 16'h0042);

        bus.start = 1'b1; bus.stop = 1'b1; bus.tick = 1'b1; cyc(1);
        bus.start = 1'b0; bus.stop = 1'b0; bus.tick = 1'b0;
        chk("stop_wins", 16'(bus.running), 16'h0);
        chk("tick_with_stop", bus.display, 16'h0042);
        bus.start = 1'b1; bus.tick = 1'b1; cyc(1);
        bus.start = 1'b0; bus.tick = 1'b0;
        chk("tick_with_start", bus.display, 16'h0042);
        bus.lap = 1'b1; bus.clear = 1'b1; cyc(1);
        bus.lap = 1'b0; bus.clear = 1'b0;
        chk("lap_clear_count", bus.display, 16'h0000);
        bus.sel_lap = 1'b1; #1;
        chk("lap_pre_clear", bus.display, 16'h0042);
        bus.sel_lap = 1'b0;

        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        ticks(3);
        chk("run_again", bus.display, 16'h0003);
        bus.mode = 2'b01; bus.ext_val = 8'h12;
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        chk("mid_reset_val", bus.display, 16'h1200);
        chk("mid_reset_idle", 16'(bus.running), 16'h0);
        bus.sel_lap = 1'b1; #1;
        chk("mid_reset_lap", bus.display, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
